ct_iu_div_cache: RTL

- Parametrised N-entry, fully associative cache of completed integer divide operations.
- Key = {sign, word, dividend, divisor}; payload = {quotient, remainder}.
- The divide unit probes the cache at issue. A registered hit lets it bypass the iterative divider. Each completed divide is written back into the cache.
- Replaces the fixed two-entry, toggle-replacement scheme with true-LRU replacement, valid bits, tag lookup and in-place update of duplicate keys.

---
 rtl/ct_iu_div_cache.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ct_iu_div_cache.sv
// Fully associative, true-LRU cache of completed integer divides keyed by {sign, word, src0, src1}.
// Define DIV_CACHE_PRELOAD_EN to load two constant entries on reset and flush instead of invalidating.
module ct_iu_div_cache #(
  parameter int ENTRY_NUM = 4,
  parameter int DATA_W    = 64,
  localparam int AGE_W    = $clog2(ENTRY_NUM)
) (
  input  logic                 div_clk,
  input  logic                 cpurst_b,
  input  logic                 cp0_iu_div_entry_disable_clr,
  input  logic                 cp0_iu_div_cache_en,
  input  logic                 lkup_vld,
  input  logic                 lkup_sign,
  input  logic                 lkup_word,
  input  logic [DATA_W-1:0]    lkup_src0,
  input  logic [DATA_W-1:0]    lkup_src1,
  output logic                 lkup_hit,
  output logic [DATA_W-1:0]    lkup_quot,
  output logic [DATA_W-1:0]    lkup_rem,
  input  logic                 wr_vld,
  input  logic                 wr_sign,
  input  logic                 wr_word,
  input  logic [DATA_W-1:0]    wr_src0,
  input  logic [DATA_W-1:0]    wr_src1,
  input  logic [DATA_W-1:0]    wr_quot,
  input  logic [DATA_W-1:0]    wr_rem,
  output logic [ENTRY_NUM-1:0] entry_vld
);

`ifdef DIV_CACHE_PRELOAD_EN
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
`endif

  logic [ENTRY_NUM-1:0] vld_r;
  logic [ENTRY_NUM-1:0] sign_r;
  logic [ENTRY_NUM-1:0] word_r;
  logic [DATA_W-1:0]    src0_r [ENTRY_NUM];
  logic [DATA_W-1:0]    src1_r [ENTRY_NUM];
  logic [DATA_W-1:0]    quot_r [ENTRY_NUM];
  logic [DATA_W-1:0]    rem_r  [ENTRY_NUM];
  logic [AGE_W-1:0]     age_r  [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] lkup_match_s;
  logic [ENTRY_NUM-1:0] wr_match_s;
  logic [AGE_W-1:0]     lkup_idx_s;
  logic [AGE_W-1:0]     wr_hit_idx_s;
  logic [AGE_W-1:0]     inv_idx_s;
  logic [AGE_W-1:0]     lru_idx_s;
  logic [AGE_W-1:0]     wr_idx_s;
  logic [AGE_W-1:0]     touch_idx_s;
  logic                 flush_s;
  logic                 lkup_fire_s;
  logic                 wr_fire_s;
  logic                 touch_fire_s;

  function automatic logic key_match(
    input logic              vld,
    input logic              sign_a,
    input logic              word_a,
    input logic [DATA_W-1:0] src0_a,
    input logic [DATA_W-1:0] src1_a,
    input logic              sign_b,
    input logic              word_b,
    input logic [DATA_W-1:0] src0_b,
    input logic [DATA_W-1:0] src1_b
  );
    return vld & (sign_a == sign_b) & (word_a == word_b) &
           (src0_a == src0_b) & (src1_a == src1_b);
  endfunction

  // Tag compare and index encoders; descending loops leave the lowest matching index.
  always_comb begin
    lkup_match_s = {ENTRY_NUM{1'b0}};
    wr_match_s   = {ENTRY_NUM{1'b0}};
    lkup_idx_s   = {AGE_W{1'b0}};
    wr_hit_idx_s = {AGE_W{1'b0}};
    inv_idx_s    = {AGE_W{1'b0}};
    lru_idx_s    = {AGE_W{1'b0}};
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      lkup_match_s[i] = key_match(vld_r[i], sign_r[i], word_r[i], src0_r[i], src1_r[i],
                                  lkup_sign, lkup_word, lkup_src0, lkup_src1);
      wr_match_s[i]   = key_match(vld_r[i], sign_r[i], word_r[i], src0_r[i], src1_r[i],
                                  wr_sign, wr_word, wr_src0, wr_src1);
      lkup_idx_s   = lkup_match_s[i] ? AGE_W'(i) : lkup_idx_s;
      wr_hit_idx_s = wr_match_s[i] ? AGE_W'(i) : wr_hit_idx_s;
      inv_idx_s    = !vld_r[i] ? AGE_W'(i) : inv_idx_s;
      lru_idx_s    = (age_r[i] == AGE_W'(ENTRY_NUM - 1)) ? AGE_W'(i) : lru_idx_s;
    end
  end

  // Request qualification, write target selection and LRU touch arbitration.
  always_comb begin
    flush_s      = cp0_iu_div_entry_disable_clr;
    lkup_fire_s  = lkup_vld & cp0_iu_div_cache_en & (|lkup_match_s) & ~flush_s;
    wr_fire_s    = wr_vld & cp0_iu_div_cache_en & ~flush_s;
    if (|wr_match_s) begin
      wr_idx_s = wr_hit_idx_s;
    end else if (!(&vld_r)) begin
      wr_idx_s = inv_idx_s;
    end else begin
      wr_idx_s = lru_idx_s;
    end
    touch_fire_s = wr_fire_s | lkup_fire_s;
    touch_idx_s  = wr_fire_s ? wr_idx_s : lkup_idx_s;
  end

  // Entry storage: reset/flush clear (or preload), otherwise write the selected target.
  always_ff @(posedge div_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_r  <= {ENTRY_NUM{1'b0}};
      sign_r <= {ENTRY_NUM{1'b0}};
      word_r <= {ENTRY_NUM{1'b0}};
      for (int i = 0; i < ENTRY_NUM; i++) begin
        src0_r[i] <= {DATA_W{1'b0}};
        src1_r[i] <= {DATA_W{1'b0}};
        quot_r[i] <= {DATA_W{1'b0}};
        rem_r[i]  <= {DATA_W{1'b0}};
      end
`ifdef DIV_CACHE_PRELOAD_EN
      vld_r[1:0] <= 2'b11;
      sign_r[1]  <= 1'b1;
      src0_r[0]  <= ALL_ONES;  src1_r[0] <= ONE;  quot_r[0] <= ALL_ONES;
      src0_r[1]  <= MAX_POS;   src1_r[1] <= ONE;  quot_r[1] <= MAX_POS;
`endif
    end else if (flush_s) begin
      vld_r <= {ENTRY_NUM{1'b0}};
`ifdef DIV_CACHE_PRELOAD_EN
      vld_r[1:0]  <= 2'b11;
      sign_r[1:0] <= 2'b10;
      word_r[1:0] <= 2'b00;
      src0_r[0] <= ALL_ONES;  src1_r[0] <= ONE;  quot_r[0] <= ALL_ONES;  rem_r[0] <= {DATA_W{1'b0}};
      src0_r[1] <= MAX_POS;   src1_r[1] <= ONE;  quot_r[1] <= MAX_POS;   rem_r[1] <= {DATA_W{1'b0}};
`endif
    end else if (wr_fire_s) begin
      vld_r[wr_idx_s]  <= 1'b1;
      sign_r[wr_idx_s] <= wr_sign;
      word_r[wr_idx_s] <= wr_word;
      src0_r[wr_idx_s] <= wr_src0;
      src1_r[wr_idx_s] <= wr_src1;
      quot_r[wr_idx_s] <= wr_quot;
      rem_r[wr_idx_s]  <= wr_rem;
    end
  end

  // LRU ages; flush leaves them untouched so they stay a permutation.
  always_ff @(posedge div_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        age_r[i] <= AGE_W'(i);
      end
    end else if (touch_fire_s) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (AGE_W'(i) == touch_idx_s) begin
          age_r[i] <= {AGE_W{1'b0}};
        end else if (age_r[i] < age_r[touch_idx_s]) begin
          age_r[i] <= age_r[i] + AGE_W'(1);
        end else begin
          age_r[i] <= age_r[i];
        end
      end
    end
  end

  // Registered lookup result; data holds on a miss.
  always_ff @(posedge div_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      lkup_hit  <= 1'b0;
      lkup_quot <= {DATA_W{1'b0}};
      lkup_rem  <= {DATA_W{1'b0}};
    end else begin
      lkup_hit <= lkup_fire_s;
      if (lkup_fire_s) begin
        lkup_quot <= quot_r[lkup_idx_s];
        lkup_rem  <= rem_r[lkup_idx_s];
      end
    end
  end

  assign entry_vld = vld_r;

endmodule
